// File: rtl/br_credit_counter_vc_pool.sv
`default_nettype none
// ============================================================================
// Module   : br_credit_counter_vc_pool
// Brief    : Sender-side credit counter for a multi-VC link. Each virtual
//            channel owns a dedicated pool. All channels share one pool that
//            they may borrow from, with one round-robin borrow per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module br_credit_counter_vc_pool #(
  parameter int NumChannels  = 2,
  parameter int DedicatedMax = 4,
  parameter int SharedMax    = 8,
  parameter int MaxChange    = 1,
  localparam int DW = $clog2(DedicatedMax + 1),
  localparam int SW = $clog2(SharedMax + 1),
  localparam int CW = $clog2(MaxChange + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NumChannels-1:0]    i_incr_valid,
  input  logic [NumChannels*CW-1:0] i_incr,
  input  logic [NumChannels-1:0]    i_decr_valid,
  input  logic [NumChannels*CW-1:0] i_decr,
  output logic [NumChannels-1:0]    o_decr_ready,
  output logic [NumChannels-1:0]    o_decr_from_shared,
  input  logic [NumChannels*DW-1:0] i_initial_dedicated,
  input  logic [SW-1:0]             i_initial_shared,
  output logic [NumChannels*DW-1:0] o_dedicated_value,
  output logic [SW-1:0]             o_shared_value,
  output logic [NumChannels*SW-1:0] o_borrowed
);

  localparam int PW = $clog2(NumChannels);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_run;

  logic [DW-1:0]   r_dedicated [NumChannels];
  logic [SW-1:0]   r_borrowed  [NumChannels];
  logic [SW-1:0]   r_shared;
  logic [PW-1:0]   r_rr_ptr;

  logic [CW-1:0]   w_inc       [NumChannels];
  logic [CW-1:0]   w_dec       [NumChannels];
  logic [SW-1:0]   w_ret       [NumChannels];
  logic [DW:0]     w_ded_avail [NumChannels];
  logic [DW:0]     w_ded_next  [NumChannels];
  logic [SW:0]     w_bor_next  [NumChannels];
  logic [DW-1:0]   w_init_ded  [NumChannels];
  logic [NumChannels-1:0] w_ded_ok;
  logic [NumChannels-1:0] w_need;
  logic [NumChannels-1:0] w_take;
  logic [NumChannels-1:0] w_split;

  logic [SW:0]     w_sh_avail;
  logic [SW:0]     w_sh_next;
  logic            w_found;
  logic [PW-1:0]   w_winner;
  logic [PW:0]     w_scan;
  logic [CW-1:0]   w_dec_win;
  logic            w_grant;
  logic [PW:0]     w_rr_inc;
  logic [PW-1:0]   w_rr_next;
  logic [31:0]     w_pool_total;

  assign w_run = (r_state == S_RUN);

  // Per-channel return split, dedicated availability and dedicated consume.
  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    logic [SW-1:0] w_inc_sw;

    assign w_inc[c]      = (w_run && i_incr_valid[c]) ? i_incr[c*CW +: CW] : '0;
    assign w_dec[c]      = i_decr[c*CW +: CW];
    assign w_init_ded[c] = i_initial_dedicated[c*DW +: DW];
    assign w_inc_sw      = SW'(w_inc[c]);

    // Returned credit pays back borrowed shared credit first.
    assign w_ret[c]       = (w_inc_sw < r_borrowed[c]) ? w_inc_sw : r_borrowed[c];
    assign w_ded_avail[c] = {1'b0, r_dedicated[c]} + (DW+1)'(w_inc[c]) - (DW+1)'(w_ret[c]);

    assign w_ded_ok[c] = w_run && i_decr_valid[c] && ((DW+1)'(w_dec[c]) <= w_ded_avail[c]);
    assign w_need[c]   = w_run && i_decr_valid[c] && !w_ded_ok[c];
    assign w_take[c]   = w_grant && (w_winner == PW'(c));
    assign w_split[c]  = (w_ret[c] != '0) && (SW'(w_inc[c]) > w_ret[c]);

    assign o_decr_ready[c]       = w_ded_ok[c] || w_take[c];
    assign o_decr_from_shared[c] = w_take[c];

    assign w_ded_next[c] = w_ded_avail[c] - (w_ded_ok[c] ? (DW+1)'(w_dec[c]) : '0);
    assign w_bor_next[c] = {1'b0, r_borrowed[c]} - (SW+1)'(w_ret[c])
                         + (w_take[c] ? (SW+1)'(w_dec[c]) : '0);

    assign o_dedicated_value[c*DW +: DW] = r_dedicated[c];
    assign o_borrowed[c*SW +: SW]        = r_borrowed[c];
  end

  assign o_shared_value = r_shared;

  // Shared availability includes every channel's same-cycle repayment.
  always_comb begin
    w_sh_avail = {1'b0, r_shared};
    for (int c = 0; c < NumChannels; c++) begin
      w_sh_avail = w_sh_avail + (SW+1)'(w_ret[c]);
    end
  end

  // Round-robin pick of the first channel needing shared credit at/after rr_ptr.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    w_scan   = '0;
    for (int i = 0; i < NumChannels; i++) begin
      w_scan = {1'b0, r_rr_ptr} + (PW+1)'(i);
      if (w_scan >= (PW+1)'(NumChannels)) begin
        w_scan = w_scan - (PW+1)'(NumChannels);
      end
      if (!w_found && w_need[w_scan[PW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_scan[PW-1:0];
      end
    end
  end

  assign w_dec_win = w_dec[w_winner];
  assign w_grant   = w_found && ((SW+1)'(w_dec_win) <= w_sh_avail);
  assign w_sh_next = w_sh_avail - (w_grant ? (SW+1)'(w_dec_win) : '0);

  // Pointer moves past the winner only on a granted borrow, so a stalled winner keeps priority.
  always_comb begin
    w_rr_inc  = {1'b0, w_winner} + (PW+1)'(1);
    w_rr_next = r_rr_ptr;
    if (w_grant) begin
      w_rr_next = (w_rr_inc >= (PW+1)'(NumChannels)) ? '0 : w_rr_inc[PW-1:0];
    end
  end

  // Init/run sequencing: a single load cycle after reset, then run forever.
  always_comb begin
    w_state_next = r_state;
    if (r_state == S_INIT) begin
      w_state_next = S_RUN;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Counter registers: loaded on the init cycle, updated every run cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shared <= '0;
      r_rr_ptr <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        r_dedicated[c] <= '0;
        r_borrowed[c]  <= '0;
      end
    end else if (r_state == S_INIT) begin
      r_shared <= i_initial_shared;
      r_rr_ptr <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        r_dedicated[c] <= w_init_ded[c];
        r_borrowed[c]  <= '0;
      end
    end else begin
      r_shared <= w_sh_next[SW-1:0];
      r_rr_ptr <= w_rr_next;
      for (int c = 0; c < NumChannels; c++) begin
        r_dedicated[c] <= w_ded_next[c][DW-1:0];
        r_borrowed[c]  <= w_bor_next[c][SW-1:0];
      end
    end
  end

`ifndef SYNTHESIS
  // Total shared credit (free plus borrowed) that the next state would hold.
  always_comb begin
    w_pool_total = 32'(w_sh_next);
    for (int c = 0; c < NumChannels; c++) begin
      w_pool_total = w_pool_total + 32'(w_bor_next[c]);
    end
  end

  // Range and conservation checks on the values about to be committed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_INIT) begin
        assert (i_initial_shared <= SW'(SharedMax))
          else $error("initial_shared out of range");
        for (int c = 0; c < NumChannels; c++) begin
          assert (w_init_ded[c] <= DW'(DedicatedMax))
            else $error("initial_dedicated out of range");
        end
      end else begin
        for (int c = 0; c < NumChannels; c++) begin
          assert (!i_incr_valid[c] || (i_incr[c*CW +: CW] <= CW'(MaxChange)))
            else $error("incr exceeds MaxChange");
          assert (!i_decr_valid[c] || (w_dec[c] <= CW'(MaxChange)))
            else $error("decr exceeds MaxChange");
          assert (w_ded_next[c] <= (DW+1)'(DedicatedMax))
            else $error("dedicated overflow");
        end
        assert (w_sh_next <= (SW+1)'(SharedMax))
          else $error("shared overflow");
        assert (w_pool_total <= 32'(SharedMax))
          else $error("shared plus borrowed exceeds SharedMax");
      end
    end
  end

  cover property (@(posedge clk) disable iff (rst) w_run && r_shared == '0);
  cover property (@(posedge clk) disable iff (rst) w_run && r_shared == SW'(SharedMax));
  cover property (@(posedge clk) disable iff (rst) w_run && r_dedicated[0] == '0);
  cover property (@(posedge clk) disable iff (rst) w_run && r_dedicated[0] == DW'(DedicatedMax));
  cover property (@(posedge clk) disable iff (rst) $countones(w_need) > 1);
  cover property (@(posedge clk) disable iff (rst) w_run && (w_split != '0));
`endif

endmodule
`default_nettype wire
